// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with configurable modulus, parallel load,
// wrap/saturate bound handling, a registered terminal-event pulse and sticky
// overflow/underflow flags. All outputs are registered; no input reaches an
// output combinationally.
module param_updown_counter #(
  parameter int          WIDTH       = 8,
  parameter int unsigned MAX_COUNT   = (2 ** WIDTH) - 1,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  // Reject parameter sets whose range cannot be represented or whose reset
  // value lies outside the counting range.
  if ((longint'(RESET_VALUE) > longint'(MAX_COUNT)) ||
      (longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1))) begin : g_param_check
    $fatal(1, "param_updown_counter: illegal MAX_COUNT/RESET_VALUE for WIDTH");
  end

  // Next count value and boundary detection. Bounds are compared explicitly
  // so that non-power-of-two moduli wrap correctly.
  logic [WIDTH-1:0] count_next;
  logic             hit_max;
  logic             hit_min;

  // Compute the counted value for this cycle assuming en=1 and no load.
  always_comb begin
    count_next = out;
    hit_max    = 1'b0;
    hit_min    = 1'b0;
    if (up_dn) begin
      if (out >= MAX_V) begin
        hit_max    = 1'b1;
        count_next = sat_mode ? MAX_V : '0;
      end else begin
        count_next = out + 1'b1;
      end
    end else begin
      if (out == '0) begin
        hit_min    = 1'b1;
        count_next = sat_mode ? '0 : MAX_V;
      end else begin
        count_next = out - 1'b1;
      end
    end
  end

  // State update with priority rst > load > en; a flag set beats clr_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= RST_V;
      tc  <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr_flags) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (load) begin
        out <= (load_val > MAX_V) ? MAX_V : load_val;
      end else if (en) begin
        out <= count_next;
        if (hit_max) begin
          tc  <= 1'b1;
          ovf <= 1'b1;
        end
        if (hit_min) begin
          tc  <= 1'b1;
          unf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter. One instance runs as
// a decade counter (WIDTH=4, MAX_COUNT=9, RESET_VALUE=0); a second runs full
// range with a non-zero reset value (WIDTH=4, MAX_COUNT=15, RESET_VALUE=7).
module tb_param_updown_counter;

  logic       clk;
  logic       rst, en, up_dn, load, sat_mode, clr_flags;
  logic [3:0] load_val;
  logic [3:0] out;
  logic       tc, ovf, unf;

  logic       b_rst, b_en, b_up_dn, b_load, b_sat_mode, b_clr_flags;
  logic [3:0] b_load_val;
  logic [3:0] b_out;
  logic       b_tc, b_ovf, b_unf;

  int errors = 0;
  int checks = 0;

  param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .clr_flags(clr_flags),
    .out(out), .tc(tc), .ovf(ovf), .unf(unf)
  );

  param_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .RESET_VALUE(7)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up_dn), .load(b_load),
    .load_val(b_load_val), .sat_mode(b_sat_mode), .clr_flags(b_clr_flags),
    .out(b_out), .tc(b_tc), .ovf(b_ovf), .unf(b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    sat_mode = 1'b0; clr_flags = 1'b0;
    tick();
    tick();
    checks++; if (out !== 4'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", out); end
    checks++; if (tc !== 1'b0)  begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", unf); end
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_o [12];
    exp_o = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (out !== exp_o[i]) begin errors++; $display("FAIL up_wrap_out[%0d] got=%0d exp=%0d", i, out, exp_o[i]); end
      checks++; if (tc !== (i == 9))  begin errors++; $display("FAIL up_wrap_tc[%0d] got=%b exp=%b", i, tc, (i == 9)); end
      checks++; if (ovf !== (i >= 9)) begin errors++; $display("FAIL up_wrap_ovf[%0d] got=%b exp=%b", i, ovf, (i >= 9)); end
      checks++; if (unf !== 1'b0)     begin errors++; $display("FAIL up_wrap_unf[%0d] got=%b exp=0", i, unf); end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap_clear();
    logic [3:0] exp_o [4];
    exp_o = '{4'd1, 4'd0, 4'd9, 4'd8};
    load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    checks++; if (out !== 4'd2) begin errors++; $display("FAIL down_load_out got=%0d exp=2", out); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL down_load_ovf_kept got=%b exp=1", ovf); end
    en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out !== exp_o[i]) begin errors++; $display("FAIL down_wrap_out[%0d] got=%0d exp=%0d", i, out, exp_o[i]); end
      checks++; if (tc !== (i == 2))  begin errors++; $display("FAIL down_wrap_tc[%0d] got=%b exp=%b", i, tc, (i == 2)); end
      checks++; if (unf !== (i >= 2)) begin errors++; $display("FAIL down_wrap_unf[%0d] got=%b exp=%b", i, unf, (i >= 2)); end
    end
    en = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL clr_unf got=%b exp=0", unf); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", ovf); end
    checks++; if (out !== 4'd8) begin errors++; $display("FAIL clr_out got=%0d exp=8", out); end
    checks++; if (tc !== 1'b0)  begin errors++; $display("FAIL clr_tc got=%b exp=0", tc); end
  endtask

  task automatic test_saturate();
    sat_mode = 1'b1; load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out !== 4'd9)     begin errors++; $display("FAIL sat_up_out[%0d] got=%0d exp=9", i, out); end
      checks++; if (tc !== (i >= 1))  begin errors++; $display("FAIL sat_up_tc[%0d] got=%b exp=%b", i, tc, (i >= 1)); end
      checks++; if (ovf !== (i >= 1)) begin errors++; $display("FAIL sat_up_ovf[%0d] got=%b exp=%b", i, ovf, (i >= 1)); end
    end
    clr_flags = 1'b1;
    tick();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL set_beats_clr_ovf got=%b exp=1", ovf); end
    checks++; if (tc !== 1'b1)  begin errors++; $display("FAIL set_beats_clr_tc got=%b exp=1", tc); end
    en = 1'b0;
    tick();
    clr_flags = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_clr_ovf got=%b exp=0", ovf); end
    checks++; if (tc !== 1'b0)  begin errors++; $display("FAIL sat_idle_tc got=%b exp=0", tc); end
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out !== 4'd0) begin errors++; $display("FAIL sat_dn_out[%0d] got=%0d exp=0", i, out); end
      checks++; if (tc !== 1'b1)  begin errors++; $display("FAIL sat_dn_tc[%0d] got=%b exp=1", i, tc); end
      checks++; if (unf !== 1'b1) begin errors++; $display("FAIL sat_dn_unf[%0d] got=%b exp=1", i, unf); end
    end
    en = 1'b0; sat_mode = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 4'd15; en = 1'b0;
    tick();
    checks++; if (out !== 4'd9) begin errors++; $display("FAIL load_clamp got=%0d exp=9", out); end
    load_val = 4'd3; en = 1'b1; up_dn = 1'b1;
    tick();
    checks++; if (out !== 4'd3) begin errors++; $display("FAIL load_over_en got=%0d exp=3", out); end
    checks++; if (tc !== 1'b0)  begin errors++; $display("FAIL load_tc got=%b exp=0", tc); end
    rst = 1'b1;
    tick();
    checks++; if (out !== 4'd0) begin errors++; $display("FAIL rst_over_load_out got=%0d exp=0", out); end
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL rst_over_load_unf got=%b exp=0", unf); end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_enable_direction();
    logic       en_v [4];
    logic       up_v [4];
    logic [3:0] exp_o [4];
    en_v  = '{1'b1, 1'b0, 1'b1, 1'b1};
    up_v  = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_o = '{4'd6, 4'd6, 4'd5, 4'd6};
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = en_v[i]; up_dn = up_v[i];
      tick();
      checks++; if (out !== exp_o[i]) begin errors++; $display("FAIL en_dir_out[%0d] got=%0d exp=%0d", i, out, exp_o[i]); end
      checks++; if (tc !== 1'b0)      begin errors++; $display("FAIL en_dir_tc[%0d] got=%b exp=0", i, tc); end
    end
    en = 1'b0;
  endtask

  task automatic test_full_range_reset();
    b_rst = 1'b1; b_en = 1'b0;
    tick();
    checks++; if (b_out !== 4'd7) begin errors++; $display("FAIL b_reset_out got=%0d exp=7", b_out); end
    b_rst = 1'b0; b_en = 1'b1; b_up_dn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (b_out !== 4'((i + 8) % 16)) begin errors++; $display("FAIL b_up_out[%0d] got=%0d exp=%0d", i, b_out, (i + 8) % 16); end
      checks++; if (b_tc !== (i == 8)) begin errors++; $display("FAIL b_up_tc[%0d] got=%b exp=%b", i, b_tc, (i == 8)); end
    end
    checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL b_wrap_ovf got=%b exp=1", b_ovf); end
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0; b_en = 1'b0;
    checks++; if (b_out !== 4'd7) begin errors++; $display("FAIL b_midrst_out got=%0d exp=7", b_out); end
    checks++; if (b_tc !== 1'b0)  begin errors++; $display("FAIL b_midrst_tc got=%b exp=0", b_tc); end
    checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL b_midrst_ovf got=%b exp=0", b_ovf); end
    checks++; if (b_unf !== 1'b0) begin errors++; $display("FAIL b_midrst_unf got=%b exp=0", b_unf); end
  endtask

  initial begin
    b_rst = 1'b1; b_en = 1'b0; b_up_dn = 1'b1; b_load = 1'b0; b_load_val = '0;
    b_sat_mode = 1'b0; b_clr_flags = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap_clear();
    test_saturate();
    test_load_priority();
    test_enable_direction();
    test_full_range_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised up/down counter, the successor to the fixed 4-bit up counter. It adds configurable width and modulus, direction control, count enable, synchronous parallel load, and a selectable wrap or saturate mode. It also provides a terminal-event pulse and sticky overflow/underflow flags. It is used as a general event/timer counter and modulo divider in the Counters library.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MAX_COUNT, 2**WIDTH-1, highest legal count; counting range is 0..MAX_COUNT (e.g. 9 gives a decade counter)
RESET_VALUE, 0, value loaded into out on reset; must be <= MAX_COUNT

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; 1 = count one step this cycle
up_dn  input  1  direction; 1 = increment, 0 = decrement
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo MAX_COUNT+1
clr_flags  input  1  clears ovf/unf
out  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle pulse: a boundary event occurred on the previous edge
ovf  output  1  sticky: an up-count was attempted at MAX_COUNT
unf  output  1  sticky: a down-count was attempted at 0

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst, and all outputs are registered.
- Reset (rst=1 at edge):
  - out=RESET_VALUE, tc=0, ovf=0, unf=0.
  - rst overrides all other inputs, including mid-count and mid-load.
- Priority per edge: rst > load > en. With en=0 and load=0, out holds and tc=0.
- Load:
  - out = min(load_val, MAX_COUNT). Values above MAX_COUNT clamp to MAX_COUNT.
  - tc=0. Flags are unchanged except by clr_flags.
- Count, up (en=1, up_dn=1):
  - out<MAX_COUNT: out+1.
  - out==MAX_COUNT: boundary event. Wrap mode gives out=0; saturate mode holds MAX_COUNT. tc=1 next cycle, ovf set.
- Count, down (en=1, up_dn=0):
  - out>0: out-1.
  - out==0: boundary event. Wrap mode gives out=MAX_COUNT; saturate mode holds 0. tc=1 next cycle, unf set.
- tc:
  - Registered and high for exactly one cycle per boundary event.
  - Consecutive saturated attempts produce tc=1 on every such cycle.
- Flags:
  - ovf/unf are set by their event and held until clr_flags=1 or rst.
  - If a set event and clr_flags occur on the same edge, set wins (flag=1).
  - clr_flags has no effect on out or tc.
- Arithmetic is done in WIDTH bits with explicit bound compare; no reliance on natural binary overflow. This keeps non-power-of-two MAX_COUNT correct.
- If a direction change happens mid-count, it takes effect on the same edge as the new up_dn value. There is no latency.
- Latency: every input affects out on the next rising edge; there is no combinational path from inputs to outputs.
- Elaboration check: RESET_VALUE>MAX_COUNT or MAX_COUNT>2**WIDTH-1 is a fatal error.

Test Plan:
Use WIDTH=4, MAX_COUNT=9, RESET_VALUE=0 unless stated otherwise.
1. Reset then count up: rst=1 for 2 cycles, then en=1, up_dn=1, sat_mode=0 for 12 cycles -> out 0,1,...,9,0,1; tc=1 only in the cycle after 9->0; ovf=1 from then on; unf=0.
2. Down wrap plus flag clear: load load_val=2, then en=1, up_dn=0 for 4 cycles -> out 2,1,0,9,8; tc pulses once; unf=1. Then pulse clr_flags -> unf=0 and out unaffected.
3. Saturate up: sat_mode=1, load 8, up for 4 cycles -> out 9,9,9,9; tc=1 on each of the 3 saturated attempts; ovf=1. Then clr_flags and an attempt on the same edge -> ovf stays 1.
4. Load clamp and priority: load_val=15 -> out=9. Then load=1, en=1, load_val=3 on the same edge -> out=3, not 4 and not 2. Then rst=1, load=1 on the same edge -> out=0.
5. Enable gating and direction switching: en toggled 1,0,1,1 with up_dn 1,1,0,1 starting from 5 -> out 6,6,5,6; tc=0 throughout.
6. Reset mid-count with RESET_VALUE=7 and full range (WIDTH=4, MAX_COUNT=15): count up to 15 and wrap to 0 with tc=1. Then assert rst while en=1 -> out=7 and tc/ovf/unf=0 on the next edge.
